// File: rtl/data_path_if.sv
// Control strobes, memory data and observation outputs of the single-bus datapath.
// Bit i of Rout/Rin selects register Ri as bus source / load target.
interface data_path_if #(
  parameter int WIDTH = 32
);
  logic             PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout;
  logic [15:0]      Rout;
  logic             MARin, PCin, MDRin, IRin, Yin;
  logic             IncPC, Read;
  logic [15:0]      Rin;
  logic             Zin_high, Zin_low, HIin, LOin;
  logic [WIDTH-1:0] Mdatain;
  logic [3:0]       operation;
  logic [WIDTH-1:0] BusMuxOut, IR_q, MAR_q, HI_q, LO_q;

  modport master (
    output PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Rout,
    output MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Rin,
    output Zin_high, Zin_low, HIin, LOin, Mdatain, operation,
    input  BusMuxOut, IR_q, MAR_q, HI_q, LO_q
  );

  modport slave (
    input  PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Rout,
    input  MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Rin,
    input  Zin_high, Zin_low, HIin, LOin, Mdatain, operation,
    output BusMuxOut, IR_q, MAR_q, HI_q, LO_q
  );
endinterface

// File: rtl/data_path.sv
// Single-bus CPU datapath: R0-R15, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO and ALU,
// all sharing one combinational bus selected by the *out strobes.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic      Clock,
  input  logic      clear,
  data_path_if.slave dp
);
  localparam int NREG = 16;

  logic [NREG-1:0][WIDTH-1:0] r_q;
  logic [WIDTH-1:0]   pc_reg, ir_reg, mar_reg, mdr_reg, y_reg, hi_reg, lo_reg, in_port_reg;
  logic [2*WIDTH-1:0] z_reg;
  logic [WIDTH-1:0]   bus, c_sext;

  logic [WIDTH-1:0]   a_op, b_op, div_b, quot, rem;
  logic [2*WIDTH-1:0] a_ext, b_ext, mul_full;
  logic [4:0]         amt;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   alu_hi, alu_lo;

  // Register file; a register strobed in and out at once keeps its value.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
    logic [WIDTH-1:0] q_reg;
    always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
        q_reg <= '0;
      end else if (dp.Rin[gi] && !dp.Rout[gi]) begin
        q_reg <= bus;
      end
    end
    assign r_q[gi] = q_reg;
  end

  assign c_sext = {{(WIDTH-19){ir_reg[18]}}, ir_reg[18:0]};

  always_comb begin
    bus = '0;
    if (|dp.Rout) begin
      for (int i = NREG - 1; i >= 0; i--) begin
        if (dp.Rout[i]) bus = r_q[i];
      end
    end
    else if (dp.HIout)      bus = hi_reg;
    else if (dp.LOout)      bus = lo_reg;
    else if (dp.Zhighout)   bus = z_reg[2*WIDTH-1:WIDTH];
    else if (dp.Zlowout)    bus = z_reg[WIDTH-1:0];
    else if (dp.PCout)      bus = pc_reg;
    else if (dp.MDRout)     bus = mdr_reg;
    else if (dp.In_Portout) bus = in_port_reg;
    else if (dp.Cout)       bus = c_sext;
  end

  assign a_op  = y_reg;
  assign b_op  = bus;
  assign amt   = b_op[4:0];
  assign a_ext = {{WIDTH{a_op[WIDTH-1]}}, a_op};
  assign b_ext = {{WIDTH{b_op[WIDTH-1]}}, b_op};
  assign mul_full = a_ext * b_ext;

  // Divider never sees a zero or overflowing divisor; those cases are patched below.
  assign div_zero = (b_op == '0);
  assign div_ovf  = (a_op == {1'b1, {(WIDTH-1){1'b0}}}) && (b_op == '1);
  assign div_b    = (div_zero || div_ovf) ? WIDTH'(1) : b_op;
  assign quot     = $signed(a_op) / $signed(div_b);
  assign rem      = $signed(a_op) % $signed(div_b);

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    if (dp.IncPC) begin
      alu_lo = b_op + WIDTH'(1);
    end else begin
      case (dp.operation)
        4'b0000: alu_lo = a_op + b_op;
        4'b0001: alu_lo = a_op - b_op;
        4'b0010: {alu_hi, alu_lo} = mul_full;
        4'b0011: begin
          if (div_zero) begin
            alu_lo = '1;
            alu_hi = a_op;
          end else if (div_ovf) begin
            alu_lo = a_op;
          end else begin
            alu_lo = quot;
            alu_hi = rem;
          end
        end
        4'b0100: alu_lo = a_op & b_op;
        4'b0101: alu_lo = a_op | b_op;
        4'b0110: alu_lo = a_op >> amt;
        4'b0111: alu_lo = a_op << amt;
        4'b1000: alu_lo = $signed(a_op) >>> amt;
        4'b1001: alu_lo = (a_op >> amt) | (a_op << (WIDTH - amt));
        4'b1010: alu_lo = (a_op << amt) | (a_op >> (WIDTH - amt));
        4'b1011: alu_lo = '0 - b_op;
        4'b1100: alu_lo = ~b_op;
        default: alu_lo = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      pc_reg      <= '0;
      ir_reg      <= '0;
      mar_reg     <= '0;
      mdr_reg     <= '0;
      y_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      z_reg       <= '0;
      in_port_reg <= '0;
    end else begin
      if (dp.PCin && !dp.PCout)       pc_reg  <= bus;
      if (dp.IRin)                    ir_reg  <= bus;
      if (dp.MARin)                   mar_reg <= bus;
      if (dp.Yin)                     y_reg   <= bus;
      if (dp.MDRin && !dp.MDRout)     mdr_reg <= dp.Read ? dp.Mdatain : bus;
      if (dp.HIin && !dp.HIout)       hi_reg  <= bus;
      if (dp.LOin && !dp.LOout)       lo_reg  <= bus;
      if (dp.Zin_high && !dp.Zhighout) z_reg[2*WIDTH-1:WIDTH] <= alu_hi;
      if (dp.Zin_low && !dp.Zlowout)   z_reg[WIDTH-1:0]       <= alu_lo;
      in_port_reg <= in_port_reg;
    end
  end

  assign dp.BusMuxOut = bus;
  assign dp.IR_q      = ir_reg;
  assign dp.MAR_q     = mar_reg;
  assign dp.HI_q      = hi_reg;
  assign dp.LO_q      = lo_reg;
endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed register-transfer sequences plus
// randomized strobe patterns compared against a behavioural register/ALU model.
module tb_data_path;
  localparam int W = 32;

  logic Clock = 1'b0;
  logic clear;
  int   checks   = 0;
  int   failures = 0;

  data_path_if #(.WIDTH(W)) bus_if ();
  data_path #(.WIDTH(W)) dut (.Clock(Clock), .clear(clear), .dp(bus_if));

  always #5 Clock = ~Clock;

  logic [31:0] r_m [16];
  logic [31:0] pc_m, ir_m, mar_m, mdr_m, y_m, hi_m, lo_m;
  logic [63:0] z_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) r_m[i] = '0;
    pc_m = '0; ir_m = '0; mar_m = '0; mdr_m = '0; y_m = '0;
    hi_m = '0; lo_m = '0; z_m = '0;
  endtask

  task automatic idle();
    bus_if.PCout = 0; bus_if.Zlowout = 0; bus_if.Zhighout = 0; bus_if.HIout = 0;
    bus_if.LOout = 0; bus_if.MDRout = 0; bus_if.In_Portout = 0; bus_if.Cout = 0;
    bus_if.Rout = '0; bus_if.Rin = '0;
    bus_if.MARin = 0; bus_if.PCin = 0; bus_if.MDRin = 0; bus_if.IRin = 0; bus_if.Yin = 0;
    bus_if.IncPC = 0; bus_if.Read = 0;
    bus_if.Zin_high = 0; bus_if.Zin_low = 0; bus_if.HIin = 0; bus_if.LOin = 0;
    bus_if.Mdatain = '0; bus_if.operation = '0;
  endtask

  function automatic logic [31:0] model_bus();
    int cv;
    for (int i = 0; i < 16; i++) if (bus_if.Rout[i]) return r_m[i];
    if (bus_if.HIout)      return hi_m;
    if (bus_if.LOout)      return lo_m;
    if (bus_if.Zhighout)   return z_m[63:32];
    if (bus_if.Zlowout)    return z_m[31:0];
    if (bus_if.PCout)      return pc_m;
    if (bus_if.MDRout)     return mdr_m;
    if (bus_if.In_Portout) return 32'h0;
    if (bus_if.Cout) begin
      cv = int'(ir_m[18:0]);
      if (cv >= (1 << 18)) cv = cv - (1 << 19);
      return 32'(cv);
    end
    return 32'h0;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic inc,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    int n;
    logic [31:0] lo, hi;
    sa = $signed(a);
    sb = $signed(b);
    n  = int'(b % 32);
    lo = '0;
    hi = '0;
    if (inc) return {32'h0, b + 32'd1};
    case (op)
      4'd0: lo = a + b;
      4'd1: lo = a - b;
      4'd2: begin p = sa * sb; return p; end
      4'd3: begin
        if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = 32'h80000000; hi = 0; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      4'd4: lo = a & b;
      4'd5: lo = a | b;
      4'd6: lo = a >> n;
      4'd7: lo = a << n;
      4'd8: begin p = sa >>> n; lo = p[31:0]; end
      4'd9: lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      4'd10: lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      4'd11: lo = 32'h0 - b;
      4'd12: lo = ~b;
      default: lo = '0;
    endcase
    return {hi, lo};
  endfunction

  // One clock of whatever strobes are currently driven; checks bus before and registers after.
  task automatic cycle(input string tag);
    logic [31:0] b;
    logic [63:0] alu;
    #1;
    b = model_bus();
    check_eq({tag, ":bus"}, bus_if.BusMuxOut, b);
    alu = ref_alu(bus_if.operation, bus_if.IncPC, y_m, b);
    @(posedge Clock);
    for (int i = 0; i < 16; i++) if (bus_if.Rin[i] && !bus_if.Rout[i]) r_m[i] = b;
    if (bus_if.PCin && !bus_if.PCout) pc_m = b;
    if (bus_if.IRin)  ir_m  = b;
    if (bus_if.MARin) mar_m = b;
    if (bus_if.Yin)   y_m   = b;
    if (bus_if.MDRin && !bus_if.MDRout) mdr_m = bus_if.Read ? bus_if.Mdatain : b;
    if (bus_if.HIin && !bus_if.HIout) hi_m = b;
    if (bus_if.LOin && !bus_if.LOout) lo_m = b;
    if (bus_if.Zin_high && !bus_if.Zhighout) z_m[63:32] = alu[63:32];
    if (bus_if.Zin_low && !bus_if.Zlowout)   z_m[31:0]  = alu[31:0];
    #1;
    idle();
    check_eq({tag, ":IR"},  bus_if.IR_q,  ir_m);
    check_eq({tag, ":MAR"}, bus_if.MAR_q, mar_m);
    check_eq({tag, ":HI"},  bus_if.HI_q,  hi_m);
    check_eq({tag, ":LO"},  bus_if.LO_q,  lo_m);
  endtask

  task automatic peek(input string tag, input logic [31:0] exp);
    #1;
    check_eq(tag, bus_if.BusMuxOut, exp);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    bus_if.Read = 1; bus_if.MDRin = 1; bus_if.Mdatain = v;
    cycle("ldmdr");
  endtask

  task automatic mdr_to_y();
    bus_if.MDRout = 1; bus_if.Yin = 1;
    cycle("ldy");
  endtask

  task automatic alu_op(input logic [3:0] op, input logic inc, input logic [31:0] bval);
    load_mdr(bval);
    bus_if.MDRout = 1; bus_if.operation = op; bus_if.IncPC = inc;
    bus_if.Zin_high = 1; bus_if.Zin_low = 1;
    cycle("alu");
  endtask

  task automatic show_z(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus_if.Zhighout = 1;
    peek({tag, ":zhi"}, exp_hi);
    cycle("zhi");
    bus_if.Zlowout = 1;
    peek({tag, ":zlo"}, exp_lo);
    cycle("zlo");
  endtask

  function automatic logic rb();
    return ($urandom_range(0, 5) == 0);
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        inc;
    int          sel;

    clear = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    bus_if.Rout[5] = 1'b1;
    #1;
    check_eq("rst:bus", bus_if.BusMuxOut, 32'h0);
    check_eq("rst:IR",  bus_if.IR_q,  32'h0);
    check_eq("rst:MAR", bus_if.MAR_q, 32'h0);
    check_eq("rst:HI",  bus_if.HI_q,  32'h0);
    check_eq("rst:LO",  bus_if.LO_q,  32'h0);
    clear = 1'b1;
    idle();

    // Load R6=3, R7=2 and divide.
    load_mdr(32'd3);
    bus_if.MDRout = 1; bus_if.Rin[6] = 1; cycle("r6");
    load_mdr(32'd2);
    bus_if.MDRout = 1; bus_if.Rin[7] = 1; cycle("r7");
    bus_if.Rout[6] = 1; peek("r6val", 32'd3); bus_if.Yin = 1; cycle("y6");
    bus_if.Rout[7] = 1; bus_if.operation = 4'b0011;
    bus_if.Zin_high = 1; bus_if.Zin_low = 1; cycle("div");
    bus_if.Zlowout = 1; bus_if.LOin = 1; cycle("lo");
    bus_if.Zhighout = 1; bus_if.HIin = 1; cycle("hi");
    check_eq("div:LO_q", bus_if.LO_q, 32'd1);
    check_eq("div:HI_q", bus_if.HI_q, 32'd1);

    // Instruction fetch.
    bus_if.PCout = 1; bus_if.MARin = 1; bus_if.IncPC = 1; bus_if.Zin_low = 1;
    cycle("fetch1");
    check_eq("fetch:MAR_q", bus_if.MAR_q, 32'h0);
    bus_if.Zlowout = 1; peek("fetch:zlo", 32'd1);
    bus_if.PCin = 1; bus_if.Read = 1; bus_if.MDRin = 1; bus_if.Mdatain = 32'h1E918000;
    cycle("fetch2");
    bus_if.PCout = 1; peek("fetch:pc", 32'd1); cycle("pc");
    bus_if.MDRout = 1; bus_if.IRin = 1; cycle("fetch3");
    check_eq("fetch:IR_q", bus_if.IR_q, 32'h1E918000);
    bus_if.Cout = 1; peek("c_sext", 32'h00018000); cycle("c");

    // Multiply and divide boundary cases, logic op.
    load_mdr(32'hFFFFFFFD); mdr_to_y(); alu_op(4'b0010, 1'b0, 32'd7);
    show_z("mul", 32'hFFFFFFFF, 32'hFFFFFFEB);
    load_mdr(32'hFFFFFFF9); mdr_to_y(); alu_op(4'b0011, 1'b0, 32'd2);
    show_z("divneg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    load_mdr(32'd5); mdr_to_y(); alu_op(4'b0011, 1'b0, 32'd0);
    show_z("div0", 32'd5, 32'hFFFFFFFF);
    load_mdr(32'h80000000); mdr_to_y(); alu_op(4'b0011, 1'b0, 32'hFFFFFFFF);
    show_z("divovf", 32'h0, 32'h80000000);
    load_mdr(32'h0F0F0000); mdr_to_y(); alu_op(4'b0100, 1'b0, 32'h00FF00FF);
    show_z("and", 32'h0, 32'h000F0000);

    // Bus priority and self-load.
    load_mdr(32'hA5A50001);
    bus_if.MDRout = 1; bus_if.Rin[1] = 1; cycle("r1");
    bus_if.Rout[1] = 1; bus_if.PCout = 1; peek("prio:r1_pc", 32'hA5A50001); cycle("prio");
    bus_if.Rout[0] = 1; bus_if.Rout[1] = 1; bus_if.Rin[1] = 1; cycle("selfload");
    bus_if.Rout[1] = 1; peek("selfload:r1", 32'hA5A50001); cycle("r1chk");

    // Random ALU transactions.
    for (int t = 0; t < 60; t++) begin
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'h0;
      if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (sel == 2) b = $urandom_range(0, 40);
      op  = 4'($urandom_range(0, 15));
      inc = ($urandom_range(0, 7) == 0);
      $display("txn %0d op=%0d inc=%0b a=%h b=%h", t, op, inc, a, b);
      load_mdr(a); mdr_to_y(); alu_op(op, inc, b);
      bus_if.Zlowout = 1; bus_if.LOin = 1; cycle("rlo");
      bus_if.Zhighout = 1; bus_if.HIin = 1; cycle("rhi");
    end

    // Random sparse strobe patterns.
    for (int t = 0; t < 150; t++) begin
      bus_if.Rout = 16'($urandom & $urandom & $urandom);
      bus_if.Rin  = 16'($urandom & $urandom);
      bus_if.PCout = rb(); bus_if.Zlowout = rb(); bus_if.Zhighout = rb(); bus_if.HIout = rb();
      bus_if.LOout = rb(); bus_if.MDRout = rb(); bus_if.In_Portout = rb(); bus_if.Cout = rb();
      bus_if.MARin = rb(); bus_if.PCin = rb(); bus_if.MDRin = rb(); bus_if.IRin = rb();
      bus_if.Yin = rb(); bus_if.IncPC = rb(); bus_if.Read = rb();
      bus_if.Zin_high = rb(); bus_if.Zin_low = rb(); bus_if.HIin = rb(); bus_if.LOin = rb();
      bus_if.Mdatain = $urandom;
      bus_if.operation = 4'($urandom_range(0, 15));
      cycle("rnd");
    end

    // Asynchronous reset in the middle of an operation.
    bus_if.Read = 1; bus_if.MDRin = 1; bus_if.Mdatain = 32'h12345678;
    bus_if.HIin = 1; bus_if.Rout[3] = 1;
    #1;
    clear = 1'b0;
    #1;
    model_reset();
    check_eq("midrst:bus", bus_if.BusMuxOut, 32'h0);
    check_eq("midrst:IR",  bus_if.IR_q,  32'h0);
    check_eq("midrst:HI",  bus_if.HI_q,  32'h0);
    @(posedge Clock);
    #1;
    clear = 1'b1;
    idle();
    load_mdr(32'hCAFEF00D);
    bus_if.MDRout = 1; peek("postrst:mdr", 32'hCAFEF00D); cycle("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
